// File: rtl/armleobus_copy_engine.sv
// armleobus_copy_engine: ArmleoBus master copying a block of 32-bit words from a source range to a destination range.
module armleobus_copy_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            error_response,
    output logic [LEN_WIDTH-1:0]  words_done,
    output logic                  m_transaction,
    output logic [2:0]            m_cmd,
    input  logic                  m_transaction_done,
    input  logic [2:0]            m_transaction_response,
    output logic [ADDR_WIDTH-1:0] m_address,
    output logic [31:0]           m_wdata,
    output logic [3:0]            m_wbyte_enable,
    input  logic [31:0]           m_rdata
);
    localparam logic [2:0] CMD_NONE     = 3'd0;
    localparam logic [2:0] CMD_READ     = 3'd1;
    localparam logic [2:0] CMD_WRITE    = 3'd2;
    localparam logic [2:0] RESP_SUCCESS = 3'd0;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] src_ptr, src_n, dst_ptr, dst_n;
    logic [LEN_WIDTH-1:0]  remaining, rem_n, words_n;
    logic [31:0]           data_buf, buf_n;
    logic                  done_n, err_n;
    logic [2:0]            resp_n;

    assign busy = state != IDLE;

    always_comb begin
        state_n = state;
        src_n   = src_ptr;
        dst_n   = dst_ptr;
        rem_n   = remaining;
        buf_n   = data_buf;
        words_n = words_done;
        err_n   = error;
        resp_n  = error_response;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    words_n = '0;
                    err_n   = 1'b0;
                    resp_n  = RESP_SUCCESS;
                    if (word_count == '0) begin
                        done_n = 1'b1;
                    end else begin
                        src_n   = src_addr;
                        dst_n   = dst_addr;
                        rem_n   = word_count;
                        state_n = READ;
                    end
                end
            end
            READ: begin
                if (m_transaction_done) begin
                    if (m_transaction_response == RESP_SUCCESS) begin
                        buf_n   = m_rdata;
                        src_n   = src_ptr + ADDR_WIDTH'(4);
                        state_n = WRITE;
                    end else begin
                        err_n   = 1'b1;
                        resp_n  = m_transaction_response;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            WRITE: begin
                if (m_transaction_done) begin
                    if (m_transaction_response == RESP_SUCCESS) begin
                        dst_n   = dst_ptr + ADDR_WIDTH'(4);
                        words_n = words_done + LEN_WIDTH'(1);
                        rem_n   = remaining - LEN_WIDTH'(1);
                        done_n  = remaining == LEN_WIDTH'(1);
                        state_n = remaining == LEN_WIDTH'(1) ? IDLE : READ;
                    end else begin
                        err_n   = 1'b1;
                        resp_n  = m_transaction_response;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they stay stable for the whole transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            src_ptr        <= '0;
            dst_ptr        <= '0;
            remaining      <= '0;
            data_buf       <= '0;
            words_done     <= '0;
            error          <= 1'b0;
            error_response <= RESP_SUCCESS;
            done           <= 1'b0;
            m_transaction  <= 1'b0;
            m_cmd          <= CMD_NONE;
            m_address      <= '0;
            m_wdata        <= '0;
            m_wbyte_enable <= 4'h0;
        end else begin
            state          <= state_n;
            src_ptr        <= src_n;
            dst_ptr        <= dst_n;
            remaining      <= rem_n;
            data_buf       <= buf_n;
            words_done     <= words_n;
            error          <= err_n;
            error_response <= resp_n;
            done           <= done_n;
            m_transaction  <= state_n != IDLE;
            m_cmd          <= state_n == READ ? CMD_READ : state_n == WRITE ? CMD_WRITE : CMD_NONE;
            m_address      <= state_n == READ ? src_n : state_n == WRITE ? dst_n : '0;
            m_wdata        <= state_n == WRITE ? buf_n : '0;
            m_wbyte_enable <= state_n == WRITE ? 4'hF : 4'h0;
        end
    end
endmodule

// File: tb/tb_armleobus_copy_engine.sv
// tb_armleobus_copy_engine: scoreboard bench with a delay-programmable memory slave and a word-level copy model.
module tb_armleobus_copy_engine;
    localparam logic [2:0] CMD_NONE = 3'd0, CMD_READ = 3'd1, CMD_WRITE = 3'd2;
    localparam logic [2:0] RESP_OK = 3'd0, RESP_INVALID = 3'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] word_count;
    logic        busy, done, error;
    logic [2:0]  error_response;
    logic [15:0] words_done;
    logic        m_transaction, m_transaction_done;
    logic [2:0]  m_cmd, m_transaction_response;
    logic [31:0] m_address, m_wdata, m_rdata;
    logic [3:0]  m_wbyte_enable;

    always #5 clk = ~clk;

    armleobus_copy_engine dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .word_count(word_count), .busy(busy), .done(done), .error(error),
        .error_response(error_response), .words_done(words_done),
        .m_transaction(m_transaction), .m_cmd(m_cmd), .m_transaction_done(m_transaction_done),
        .m_transaction_response(m_transaction_response), .m_address(m_address),
        .m_wdata(m_wdata), .m_wbyte_enable(m_wbyte_enable), .m_rdata(m_rdata)
    );

    // Slave: 4 KiB mirrored memory, answers k_delay cycles after a request appears, rejects misaligned addresses.
    int          k_delay = 0;
    int          cnt = 0;
    logic [31:0] mem [0:1023];
    logic [31:0] ref_mem [0:1023];

    assign m_transaction_done     = m_transaction && cnt == k_delay;
    assign m_transaction_response = m_address[1:0] != 2'b00 ? RESP_INVALID : RESP_OK;
    assign m_rdata                = m_address[1:0] != 2'b00 ? 32'h0 : mem[m_address[11:2]];

    always @(posedge clk) begin
        cnt <= (!m_transaction || m_transaction_done) ? 0 : cnt + 1;
        if (m_transaction && m_transaction_done && m_cmd == CMD_WRITE && m_address[1:0] == 2'b00)
            mem[m_address[11:2]] <= m_wdata;
    end

    typedef struct { logic [2:0] cmd; logic [31:0] addr; logic [31:0] data; } bus_t;
    typedef struct { logic [15:0] words; logic err; logic [2:0] resp; } st_t;
    bus_t exp_bus[$];
    st_t  exp_st[$];

    int checks = 0, errors = 0, done_seen = 0;
    bit mon_en = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: word-by-word copy over the shadow memory; stops at the first misaligned access.
    task automatic model(input logic [31:0] src, input logic [31:0] dst, input int n);
        st_t st;
        st = '{16'd0, 1'b0, RESP_OK};
        for (int i = 0; i < n; i++) begin
            logic [31:0] s, d, v;
            s = src + 32'(4 * i);
            d = dst + 32'(4 * i);
            exp_bus.push_back('{CMD_READ, s, 32'h0});
            if (s[1:0] != 2'b00) begin st.err = 1'b1; st.resp = RESP_INVALID; break; end
            v = ref_mem[s[11:2]];
            exp_bus.push_back('{CMD_WRITE, d, v});
            if (d[1:0] != 2'b00) begin st.err = 1'b1; st.resp = RESP_INVALID; break; end
            ref_mem[d[11:2]] = v;
            st.words++;
        end
        exp_st.push_back(st);
    endtask

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (m_transaction && m_transaction_done) begin
                if (exp_bus.size() == 0) chk("bus_unexpected", {61'd0, m_cmd}, 64'd0);
                else begin
                    bus_t e;
                    e = exp_bus.pop_front();
                    chk("bus_cmd", {61'd0, m_cmd}, {61'd0, e.cmd});
                    chk("bus_addr", {32'd0, m_address}, {32'd0, e.addr});
                    chk("bus_be", {60'd0, m_wbyte_enable}, e.cmd == CMD_WRITE ? 64'hF : 64'h0);
                    if (e.cmd == CMD_WRITE) chk("bus_wdata", {32'd0, m_wdata}, {32'd0, e.data});
                end
            end
            if (done) begin
                done_seen++;
                chk("busy_at_done", {63'd0, busy}, 64'd0);
                chk("trans_at_done", {63'd0, m_transaction}, 64'd0);
                if (exp_st.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
                else begin
                    st_t e;
                    e = exp_st.pop_front();
                    chk("words_done", {48'd0, words_done}, {48'd0, e.words});
                    chk("error", {63'd0, error}, {63'd0, e.err});
                    chk("error_response", {61'd0, error_response}, {61'd0, e.resp});
                end
            end
        end
    end

    task automatic mem_compare();
        int diffs = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk("mem_image", 64'(diffs), 64'd0);
    endtask

    task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int n, input int k,
                           input bit dup, output int first, output int done_at);
        int base;
        k_delay = k;
        model(src, dst, n);
        base = done_seen;
        @(negedge clk);
        start = 1'b1; src_addr = src; dst_addr = dst; word_count = n[15:0];
        @(posedge clk);
        #1 start = 1'b0;
        first = -1;
        done_at = -1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (dup && c == 2) begin start = 1'b1; src_addr = src + 32'h300; word_count = 16'd5; end
            if (dup && c == 3) start = 1'b0;
            if (m_transaction && first < 0) first = c;
            if (done) begin done_at = c; break; end
        end
        if (done_at < 0) chk("job_timeout", 64'd1, 64'd0);
        repeat (3) @(negedge clk);
        chk("done_pulses", 64'(done_seen - base), 64'd1);
        chk("bus_queue_drained", 64'(exp_bus.size()), 64'd0);
        mem_compare();
    endtask

    initial begin
        int first, done_at, wcount, hit, base;
        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; word_count = '0;
        for (int i = 0; i < 1024; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
        for (int i = 0; i < 4; i++) begin mem[i] = 32'h11111111 * (i + 1); ref_mem[i] = mem[i]; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        chk("rst_resp", {61'd0, error_response}, 64'd0);
        chk("rst_words", {48'd0, words_done}, 64'd0);
        chk("rst_trans", {63'd0, m_transaction}, 64'd0);
        chk("rst_cmd", {61'd0, m_cmd}, 64'd0);
        chk("rst_addr", {32'd0, m_address}, 64'd0);
        chk("rst_wdata", {32'd0, m_wdata}, 64'd0);
        chk("rst_be", {60'd0, m_wbyte_enable}, 64'd0);
        rst = 1'b0;

        run_job(32'h0, 32'h100, 4, 2, 1'b0, first, done_at);
        chk("first_req_latency", 64'(first), 64'd0);
        chk("job_cycles_k2", 64'(done_at - first), 64'd24);
        chk("dst_word3", {32'd0, mem[67]}, 64'h44444444);

        run_job(32'h40, 32'h140, 0, 1, 1'b0, first, done_at);
        chk("zero_done_latency", 64'(done_at), 64'd0);
        chk("zero_no_trans", 64'(first), 64'hFFFF_FFFF_FFFF_FFFF);

        run_job(32'h2, 32'h200, 2, 1, 1'b0, first, done_at);
        run_job(32'h10, 32'hFFFF_FFFC, 2, 1, 1'b0, first, done_at);
        run_job(32'h80, 32'h280, 3, 2, 1'b1, first, done_at);
        run_job(32'h90, 32'h2A2, 2, 0, 1'b0, first, done_at);

        for (int j = 0; j < 20; j++) begin
            logic [31:0] s, d;
            s = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
            d = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
            if ($urandom_range(0, 7) == 0) s[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) d[1:0] = 2'($urandom_range(1, 3));
            run_job(s, d, $urandom_range(0, 6), $urandom_range(0, 3), 1'b0, first, done_at);
        end

        // Reset during the second write: nothing completes and everything returns to idle.
        mon_en = 1'b0;
        k_delay = 1;
        base = done_seen;
        @(negedge clk);
        start = 1'b1; src_addr = 32'h40; dst_addr = 32'h380; word_count = 16'd4;
        @(posedge clk);
        #1 start = 1'b0;
        wcount = 0;
        hit = 0;
        for (int c = 0; c < 200 && hit == 0; c++) begin
            @(negedge clk);
            if (m_transaction && m_cmd == CMD_WRITE && wcount == 1) hit = 1;
            else if (m_transaction && m_transaction_done && m_cmd == CMD_WRITE) wcount++;
        end
        chk("reset_hit_write2", 64'(hit), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("mid_rst_trans", {63'd0, m_transaction}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_done", {63'd0, done}, 64'd0);
        chk("mid_rst_cmd", {61'd0, m_cmd}, 64'd0);
        chk("mid_rst_addr", {32'd0, m_address}, 64'd0);
        chk("mid_rst_wdata", {32'd0, m_wdata}, 64'd0);
        chk("mid_rst_be", {60'd0, m_wbyte_enable}, 64'd0);
        chk("mid_rst_words", {48'd0, words_done}, 64'd0);
        repeat (10) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("mid_rst_no_done", 64'(done_seen - base), 64'd0);
        chk("mid_rst_word0", {32'd0, mem[224]}, {32'd0, ref_mem[16]});
        chk("mid_rst_word2", {32'd0, mem[226]}, {32'd0, ref_mem[226]});
        chk("mid_rst_word3", {32'd0, mem[227]}, {32'd0, ref_mem[227]});
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
        mon_en = 1'b1;

        run_job(32'h100, 32'h3C0, 3, 1, 1'b0, first, done_at);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
